// File: rtl/sysid_probe_master.sv
// Avalon-MM read master that fetches the system-ID word and the build-timestamp
// word, compares both against expected values and reports done/match/timeout.
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1618201335,
  parameter int unsigned TIMEOUT_CYCLES     = 32'd255,
  parameter int unsigned MAX_RETRIES        = 32'd3,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [16:0] TMO_LIM_C   = 17'(TIMEOUT_CYCLES);
  localparam logic [3:0]  RETRY_LIM_C = 4'(MAX_RETRIES);

  state_t      state_r, state_s;
  logic        first_r;
  logic [15:0] tmo_r, tmo_s;
  logic [3:0]  retry_r, retry_s;
  logic [31:0] id_r, id_s, ts_r, ts_s;
  logic        done_r, done_s, match_r, match_s, terr_r, terr_s;
  logic        read_r, read_s, addr_r, addr_s, busy_r, busy_s;
  logic [16:0] tmo_inc_s;
  logic        tmo_hit_s, accept_s;

  // Next-state, counter and status computation
  always_comb begin
    state_s   = state_r;
    tmo_s     = tmo_r;
    retry_s   = retry_r;
    id_s      = id_r;
    ts_s      = ts_r;
    done_s    = done_r;
    match_s   = match_r;
    terr_s    = terr_r;
    tmo_inc_s = {1'b0, tmo_r} + 17'd1;
    tmo_hit_s = (tmo_inc_s >= TMO_LIM_C);
    accept_s  = read_r & ~avm_waitrequest;
    case (state_r)
      IDLE: begin
        if (start || (AUTO_START && first_r)) begin
          state_s = ID_REQ;
          tmo_s   = 16'd0;
          retry_s = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      ID_REQ, ID_WAIT: begin
        // data on the acceptance edge counts as captured
        if (avm_readdatavalid && ((state_r == ID_WAIT) || accept_s)) begin
          id_s    = avm_readdata;
          state_s = TS_REQ;
          tmo_s   = 16'd0;
        end else if (tmo_hit_s) begin
          state_s = DRAIN;
          tmo_s   = 16'd0;
        end else if ((state_r == ID_REQ) && accept_s) begin
          state_s = ID_WAIT;
          tmo_s   = tmo_inc_s[15:0];
        end else begin
          tmo_s   = tmo_inc_s[15:0];
        end
      end
      TS_REQ, TS_WAIT: begin
        if (avm_readdatavalid && ((state_r == TS_WAIT) || accept_s)) begin
          ts_s    = avm_readdata;
          state_s = DONE;
          done_s  = 1'b1;
          terr_s  = 1'b0;
          match_s = (id_r == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
        end else if (tmo_hit_s) begin
          state_s = DRAIN;
          tmo_s   = 16'd0;
        end else if ((state_r == TS_REQ) && accept_s) begin
          state_s = TS_WAIT;
          tmo_s   = tmo_inc_s[15:0];
        end else begin
          tmo_s   = tmo_inc_s[15:0];
        end
      end
      DRAIN: begin
        // late responses from the abandoned read are dropped here
        if (tmo_hit_s) begin
          tmo_s = 16'd0;
          if ((retry_r < RETRY_LIM_C) && (retry_r != 4'hF)) begin
            retry_s = retry_r + 4'd1;
            state_s = ID_REQ;
          end else begin
            state_s = DONE;
            done_s  = 1'b1;
            terr_s  = 1'b1;
            match_s = 1'b0;
          end
        end else begin
          tmo_s = tmo_inc_s[15:0];
        end
      end
      DONE: begin
        if (start) begin
          state_s = ID_REQ;
          done_s  = 1'b0;
          match_s = 1'b0;
          terr_s  = 1'b0;
          retry_s = 4'd0;
          tmo_s   = 16'd0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bus command and busy flag follow the state being entered so they register cleanly
  always_comb begin
    read_s = (state_s == ID_REQ) || (state_s == TS_REQ);
    addr_s = (state_s == TS_REQ) || (state_s == TS_WAIT);
    busy_s = (state_s != IDLE) && (state_s != DONE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      first_r <= 1'b1;
      tmo_r   <= 16'd0;
      retry_r <= 4'd0;
      id_r    <= 32'd0;
      ts_r    <= 32'd0;
      done_r  <= 1'b0;
      match_r <= 1'b0;
      terr_r  <= 1'b0;
      read_r  <= 1'b0;
      addr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      first_r <= 1'b0;
      tmo_r   <= tmo_s;
      retry_r <= retry_s;
      id_r    <= id_s;
      ts_r    <= ts_s;
      done_r  <= done_s;
      match_r <= match_s;
      terr_r  <= terr_s;
      read_r  <= read_s;
      addr_r  <= addr_s;
      busy_r  <= busy_s;
    end
  end

  assign avm_read    = read_r;
  assign avm_address = addr_r;
  assign id_value    = id_r;
  assign ts_value    = ts_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign match       = match_r;
  assign timeout_err = terr_r;

endmodule

// File: tb/tb_sysid_probe_master.sv
// Randomized scoreboard bench for sysid_probe_master: a behavioural Avalon slave
// serves two words; expected results are queued per sequence and checked on done.
module tb_sysid_probe_master;

  localparam logic [31:0] EXP_ID  = 32'd0;
  localparam logic [31:0] EXP_TS  = 32'd1618201335;
  localparam int          TMO     = 8;
  localparam int          RETRIES = 2;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        match;
    logic        terr;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n, start;
  logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata, id_value, ts_value;
  logic        busy, done, match, timeout_err;
  logic [69:0] outs;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb_q[$];
  logic [31:0] last_id, last_ts;
  logic [31:0] mem[2];
  int          cfg_stall, cfg_lat;
  bit          cfg_late;
  bit          inject_rdv;
  logic [31:0] inject_data;
  int          acc_cnt[2];
  int          acc_cyc[$];
  int          pend_due, stall_left;
  logic [31:0] pend_data;
  bit          in_cmd, done_q, rw_q, addr_q;

  sysid_probe_master #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES(RETRIES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata), .id_value(id_value), .ts_value(ts_value),
    .busy(busy), .done(done), .match(match), .timeout_err(timeout_err)
  );

  assign outs = {avm_address, avm_read, id_value, ts_value, busy, done, match, timeout_err};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a completed sequence reports both words and whether both equal the expected constants
  task automatic push_expect(input logic [31:0] id, input logic [31:0] ts);
    exp_t e;
    e.id = id; e.ts = ts; e.match = (id == EXP_ID) && (ts == EXP_TS); e.terr = 1'b0;
    sb_q.push_back(e);
    last_id = id;
    last_ts = ts;
  endtask

  task automatic push_timeout();
    exp_t e;
    e.id = last_id; e.ts = last_ts; e.match = 1'b0; e.terr = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int bound, output int took);
    took = 0;
    while (!done && took < bound) begin
      @(negedge clock); #1;
      took++;
    end
    check("wait_done", done, 1'b1);
  endtask

  // Behavioural slave: stalls, accepts, and returns word data after cfg_lat cycles
  initial begin
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
    pend_due = -1; in_cmd = 1'b0; stall_left = 0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      if (!reset_n) begin
        pend_due = -1;
        in_cmd   = 1'b0;
      end else begin
        if (inject_rdv) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = inject_data;
        end
        if (pend_due > 0) begin
          pend_due--;
          if (pend_due == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_data;
            pend_due          = -1;
          end
        end
        if (avm_read) begin
          if (!in_cmd) begin
            in_cmd     = 1'b1;
            stall_left = cfg_stall;
          end
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            in_cmd = 1'b0;
            acc_cnt[avm_address]++;
            if (!avm_address) acc_cyc.push_back(cyc);
            if (cfg_lat == 0) begin
              avm_readdatavalid = 1'b1;
              avm_readdata      = mem[avm_address];
            end else begin
              pend_due  = cfg_lat;
              pend_data = cfg_late ? 32'hDEAD_BEEF : mem[avm_address];
            end
          end
        end else begin
          in_cmd = 1'b0;
        end
      end
    end
  end

  // Monitor: stall stability every cycle, scoreboard pop on each rising done
  initial begin
    exp_t e;
    done_q = 1'b0; rw_q = 1'b0; addr_q = 1'b0;
    forever begin
      @(negedge clock); #1;
      if (reset_n && rw_q) check("stall_hold", {avm_read, avm_address}, {1'b1, addr_q});
      rw_q   = reset_n && avm_read && avm_waitrequest;
      addr_q = avm_address;
      if (done && !done_q) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin
          e = sb_q.pop_front();
          check("sb_id", id_value, e.id);
          check("sb_ts", ts_value, e.ts);
          check("sb_match", match, e.match);
          check("sb_timeout_err", timeout_err, e.terr);
        end
      end
      done_q = done;
    end
  end

  task automatic run_seq(input bit is_timeout, input bit poke_busy);
    int took;
    acc_cnt[0] = 0; acc_cnt[1] = 0; acc_cyc.delete();
    @(negedge clock); #1;
    inject_rdv = 1'b1; inject_data = $urandom;
    @(negedge clock); #1;
    inject_rdv = 1'b0;
    @(negedge clock); #1;
    check("done_ignores_rdv", {done, id_value, ts_value}, {1'b1, last_id, last_ts});
    if (is_timeout) push_timeout(); else push_expect(mem[0], mem[1]);
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    check("start_clears_status", {done, match, timeout_err, busy}, 4'b0001);
    if (poke_busy) begin
      repeat (2) @(negedge clock);
      #1; start = 1'b1;
      @(negedge clock); #1;
      start = 1'b0;
    end
    wait_done(is_timeout ? 120 : 40, took);
    if (is_timeout) begin
      check("timeout_id_attempts", acc_cnt[0], RETRIES + 1);
      check("timeout_ts_attempts", acc_cnt[1], 0);
      for (int i = 1; i < acc_cyc.size(); i++)
        check("retry_spacing", acc_cyc[i] - acc_cyc[i-1], 2 * TMO);
    end else begin
      check("id_reads", acc_cnt[0], 1);
      check("ts_reads", acc_cnt[1], 1);
    end
  endtask

  initial begin
    int took;
    reset_n = 1'b0; start = 1'b0; inject_rdv = 1'b0; inject_data = 32'd0;
    cfg_stall = 0; cfg_lat = 1; cfg_late = 1'b0;
    mem[0] = EXP_ID; mem[1] = EXP_TS;
    last_id = 32'd0; last_ts = 32'd0;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    repeat (3) @(negedge clock);
    #1;
    check("reset_outputs", outs, 70'd0);

    // Auto start, zero-wait slave
    push_expect(mem[0], mem[1]);
    reset_n = 1'b1;
    wait_done(40, took);
    check("auto_done_latency", took, 5);
    check("auto_id_reads", acc_cnt[0], 1);
    check("auto_ts_reads", acc_cnt[1], 1);
    check("auto_ts_value", ts_value, EXP_TS);

    // Three-cycle stall on each read
    cfg_stall = 3;
    run_seq(1'b0, 1'b0);

    // Wrong timestamp
    cfg_stall = 0;
    mem[1] = 32'h1234_5678;
    run_seq(1'b0, 1'b0);
    check("mismatch_ts_value", ts_value, 32'h1234_5678);

    // Randomized slave timing and contents; first run also pokes start while busy
    for (int i = 0; i < 8; i++) begin
      int mode;
      cfg_stall = $urandom_range(0, 3);
      cfg_lat   = $urandom_range(0, 2);
      mode      = $urandom_range(0, 3);
      mem[0] = mode[0] ? $urandom : EXP_ID;
      mem[1] = mode[1] ? $urandom : EXP_TS;
      run_seq(1'b0, i == 0);
    end

    // Slave answers too late for every attempt
    cfg_stall = 0; cfg_lat = 10; cfg_late = 1'b1;
    run_seq(1'b1, 1'b0);
    cfg_lat = 1; cfg_late = 1'b0;
    mem[0] = EXP_ID; mem[1] = EXP_TS;
    run_seq(1'b0, 1'b0);

    // Asynchronous reset in TS_WAIT, then automatic rerun
    cfg_lat = 2;
    @(negedge clock); #1;
    push_expect(mem[0], mem[1]);
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    took = 0;
    while (!(busy && avm_address && !avm_read) && took < 20) begin
      @(negedge clock); #1;
      took++;
    end
    check("reach_ts_wait", {busy, avm_address, avm_read}, 3'b110);
    #2;
    reset_n = 1'b0;
    void'(sb_q.pop_back());
    last_id = 32'd0; last_ts = 32'd0;
    #1;
    check("async_reset_clear", outs, 70'd0);
    repeat (2) @(negedge clock);
    #1;
    cfg_lat = 1;
    push_expect(mem[0], mem[1]);
    reset_n = 1'b1;
    wait_done(40, took);
    check("rerun_done_latency", took, 5);
    check("rerun_match", match, 1'b1);

    repeat (2) @(negedge clock);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
